frv_wb_arb: RTL and testbench
=============================

FRV_WB_ARB -- requirements
Module: frv_wb_arb

Interface
REQ-001 Parameter NMASTER, default 2, number of Wishbone masters sharing one bus; legal range 1..8.
REQ-002 Parameter TIMEOUT, default 255, number of stalled strobe cycles before an error response; 0 disables the timeout.
REQ-003 Ports clk_i input 1, single clock; rst_in input 1, asynchronous active-low reset.
REQ-004 Ports m_cyc_i, m_stb_i, m_we_i input NMASTER, per-master Wishbone classic cycle, strobe and write enable.
REQ-005 Ports m_be_i input 4*NMASTER and m_adr_i, m_dat_i input 32*NMASTER, per-master byte enables, address and write data; master k occupies slice k.
REQ-006 Ports m_dat_o output 32, read data broadcast to all masters; m_ack_o, m_err_o output NMASTER, per-master acknowledge and error.
REQ-007 Ports s_cyc_o, s_stb_o, s_we_o output 1; s_be_o output 4; s_adr_o, s_dat_o output 32: shared slave-side request.
REQ-008 Ports s_dat_i input 32, s_ack_i input 1: shared slave-side response.
REQ-009 Port gnt_o output NMASTER, one-hot current grant, all zero when idle.

Function
REQ-010 The FSM SHALL have exactly two states, IDLE and BUSY.
REQ-011 In IDLE, when any master has m_cyc_i and m_stb_i high, the block SHALL register a grant to the first requesting index at or after rr_ptr (modulo NMASTER) and enter BUSY on the next edge.
REQ-012 Arbitration latency SHALL be one cycle: s_cyc_o is low in the cycle a request first appears in IDLE.
REQ-013 On grant, rr_ptr SHALL become (granted index + 1) mod NMASTER.
REQ-014 In BUSY, s_cyc_o, s_stb_o, s_we_o, s_be_o, s_adr_o and s_dat_o SHALL combinationally follow the granted master; in IDLE they SHALL be zero.
REQ-015 s_ack_i SHALL be routed combinationally to m_ack_o of the granted master only; all other m_ack_o SHALL stay low.
REQ-016 m_dat_o SHALL equal s_dat_i at all times.
REQ-017 The grant SHALL be held while the granted master keeps m_cyc_i high, including across multiple back-to-back strobes.
REQ-018 When the granted master drops m_cyc_i, s_cyc_o SHALL fall in the same cycle and the FSM SHALL return to IDLE on the next edge.
REQ-019 A 8-bit stall counter SHALL increment each BUSY cycle with s_stb_o high and s_ack_i low, and clear on s_ack_i or on leaving BUSY.
REQ-020 If TIMEOUT is not 0 and the counter equals TIMEOUT, the block SHALL assert m_err_o of the granted master for one cycle, force s_cyc_o and s_stb_o low that cycle, and return to IDLE.
REQ-021 If s_ack_i and the timeout condition coincide, the ack SHALL win: the counter clears and no error is raised.
REQ-022 Requests from non-granted masters SHALL be ignored and need no ack until they are granted.
REQ-023 With NMASTER=1 the block SHALL behave as a pass-through that still has one cycle of arbitration latency and the timeout.

Reset
REQ-024 While rst_in is low: state IDLE, rr_ptr 0, counter 0, gnt_o 0, all s_* outputs, m_ack_o and m_err_o 0.
REQ-025 Reset asserted mid-transfer SHALL drop s_cyc_o immediately (asynchronously) with no ack or error generated.

Structure
REQ-026 The state enum and the counter width constant SHALL live in the shared package frv_pkg.
REQ-027 The round-robin picker SHALL be a sub-module frv_rr_pick: combinational, with req and ptr in and a one-hot gnt out.

Verification
REQ-028 NMASTER=2, both masters request in the same cycle from reset -> master 0 is granted (gnt_o=01); after it releases, master 1 is granted next (gnt_o=10).
REQ-029 Master 0 reads 0x10, slave acks with 0xDEADBEEF after 3 cycles -> m_ack_o=01 for one cycle, m_dat_o=0xDEADBEEF, nothing reaches master 1.
REQ-030 TIMEOUT=4, slave never acks -> m_err_o pulses on the granted master exactly 4 stall cycles after the strobe, s_cyc_o is low that cycle, state returns to IDLE.
REQ-031 TIMEOUT=4, s_ack_i arrives on the 4th stall cycle -> ack only, m_err_o stays 0.
REQ-032 Master 1 holds m_cyc_i for 3 back-to-back writes while master 0 requests -> master 1 keeps the grant for all 3, and master 0 is granted 1 cycle after master 1 drops m_cyc_i.
REQ-033 rst_in pulsed low during a BUSY transfer -> s_cyc_o is 0 immediately, gnt_o=0, and after release the first grant goes to master 0.

Source files
------------

// File: rtl/frv_pkg.sv
// Shared types and constants for the frv Wishbone arbiter slice.
package frv_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    localparam int CNT_W = 8;

    // Width of a master-index pointer; never zero so NMASTER=1 still has a real port.
    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/frv_rr_pick.sv
// Combinational round-robin picker: first set req bit at or after ptr, wrapping.
module frv_rr_pick
    import frv_pkg::*;
#(
    parameter int N  = 2,
    parameter int PW = ptr_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);

    logic [PW-1:0] idx;

    // Walk offsets from farthest to nearest so the nearest requester overwrites.
    always_comb begin
        gnt = '0;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = PW'((int'(ptr) + i) % N);
            if (|(req & (N'(1) << idx))) begin
                gnt = N'(1) << idx;
            end
        end
    end

endmodule

// File: rtl/frv_wb_arb.sv
// Round-robin Wishbone classic arbiter: NMASTER masters onto one slave, with stall timeout.
module frv_wb_arb
    import frv_pkg::*;
#(
    parameter int NMASTER = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                    clk_i,
    input  logic                    rst_in,
    input  logic [NMASTER-1:0]      m_cyc_i,
    input  logic [NMASTER-1:0]      m_stb_i,
    input  logic [NMASTER-1:0]      m_we_i,
    input  logic [4*NMASTER-1:0]    m_be_i,
    input  logic [32*NMASTER-1:0]   m_adr_i,
    input  logic [32*NMASTER-1:0]   m_dat_i,
    output logic [31:0]             m_dat_o,
    output logic [NMASTER-1:0]      m_ack_o,
    output logic [NMASTER-1:0]      m_err_o,
    output logic                    s_cyc_o,
    output logic                    s_stb_o,
    output logic                    s_we_o,
    output logic [3:0]              s_be_o,
    output logic [31:0]             s_adr_o,
    output logic [31:0]             s_dat_o,
    input  logic [31:0]             s_dat_i,
    input  logic                    s_ack_i,
    output logic [NMASTER-1:0]      gnt_o
);

    localparam int              PW     = ptr_w(NMASTER);
    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

    arb_state_e         state_q, state_d;
    logic [NMASTER-1:0] gnt_q, gnt_d;
    logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [NMASTER-1:0] req, pick;
    logic [PW-1:0]      pick_idx;
    logic               sel_cyc, sel_stb, sel_we;
    logic [3:0]         sel_be;
    logic [31:0]        sel_adr, sel_dat;
    logic               busy, timeout_hit;

    assign req  = m_cyc_i & m_stb_i;
    assign busy = (state_q == BUSY);

    frv_rr_pick #(.N(NMASTER), .PW(PW)) u_pick (
        .req (req),
        .ptr (rr_ptr_q),
        .gnt (pick)
    );

    // gnt_q is all-zero outside BUSY, so this mux also yields zeros when idle.
    always_comb begin
        sel_cyc  = 1'b0;
        sel_stb  = 1'b0;
        sel_we   = 1'b0;
        sel_be   = '0;
        sel_adr  = '0;
        sel_dat  = '0;
        pick_idx = '0;
        for (int k = 0; k < NMASTER; k++) begin
            if (gnt_q[k]) begin
                sel_cyc = m_cyc_i[k];
                sel_stb = m_stb_i[k];
                sel_we  = m_we_i[k];
                sel_be  = m_be_i[4*k +: 4];
                sel_adr = m_adr_i[32*k +: 32];
                sel_dat = m_dat_i[32*k +: 32];
            end
            if (pick[k]) begin
                pick_idx = PW'(k);
            end
        end
    end

    // A same-cycle ack beats the timeout.
    assign timeout_hit = (TIMEOUT != 0) && busy && (cnt_q == TO_VAL) && !s_ack_i;

    assign s_cyc_o = busy & sel_cyc & ~timeout_hit;
    assign s_stb_o = busy & sel_stb & ~timeout_hit;
    assign s_we_o  = busy & sel_we;
    assign s_be_o  = busy ? sel_be  : 4'h0;
    assign s_adr_o = busy ? sel_adr : 32'h0;
    assign s_dat_o = busy ? sel_dat : 32'h0;

    assign m_dat_o = s_dat_i;
    assign m_ack_o = busy ? (gnt_q & {NMASTER{s_ack_i}}) : '0;
    assign m_err_o = gnt_q & {NMASTER{timeout_hit}};
    assign gnt_o   = gnt_q;

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = '0;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d  = BUSY;
                    gnt_d    = pick;
                    rr_ptr_d = PW'((int'(pick_idx) + 1) % NMASTER);
                end
            end
            BUSY: begin
                if (!sel_cyc || timeout_hit) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                end else if (sel_stb && !s_ack_i) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_frv_wb_arb.sv
// Self-checking bench for frv_wb_arb (2 masters, timeout of 4 stall cycles).
module tb_frv_wb_arb;

    localparam int NM = 2;
    localparam int TO = 4;

    logic              clk_i = 1'b0;
    logic              rst_in = 1'b0;
    logic [NM-1:0]     m_cyc_i, m_stb_i, m_we_i;
    logic [4*NM-1:0]   m_be_i;
    logic [32*NM-1:0]  m_adr_i, m_dat_i;
    logic [31:0]       m_dat_o;
    logic [NM-1:0]     m_ack_o, m_err_o, gnt_o;
    logic              s_cyc_o, s_stb_o, s_we_o;
    logic [3:0]        s_be_o;
    logic [31:0]       s_adr_o, s_dat_o, s_dat_i;
    logic              s_ack_i;

    int n_chk = 0;
    int n_fail = 0;

    frv_wb_arb #(.NMASTER(NM), .TIMEOUT(TO)) dut (
        .clk_i(clk_i), .rst_in(rst_in),
        .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i), .m_be_i(m_be_i),
        .m_adr_i(m_adr_i), .m_dat_i(m_dat_i),
        .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_be_o(s_be_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
        .gnt_o(gnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_all();
        m_cyc_i = '0; m_stb_i = '0; m_we_i = '0; m_be_i = '0;
        m_adr_i = '0; m_dat_i = '0; s_ack_i = 1'b0; s_dat_i = '0;
    endtask

    task automatic drive(input int k, input logic cyc, input logic stb, input logic we,
                         input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] be);
        m_cyc_i[k] = cyc; m_stb_i[k] = stb; m_we_i[k] = we;
        m_adr_i[32*k +: 32] = adr; m_dat_i[32*k +: 32] = dat; m_be_i[4*k +: 4] = be;
    endtask

    task automatic do_reset();
        idle_all();
        rst_in = 1'b0;
        tick();
        #2 rst_in = 1'b1;
        tick();
    endtask

    // Reference arbitration: first requester at or after ptr, wrapping.
    function automatic int model_pick(input logic [NM-1:0] mask, input int ptr);
        for (int off = 0; off < NM; off++) begin
            if (mask[(ptr + off) % NM]) return (ptr + off) % NM;
        end
        return -1;
    endfunction

    task automatic test_reset();
        idle_all();
        rst_in = 1'b0;
        drive(1, 1'b1, 1'b1, 1'b1, 32'h1234, 32'h5678, 4'hF);
        s_ack_i = 1'b1; s_dat_i = 32'hA5A5_0F0F;
        tick(); tick(); #1;
        n_chk++; if (gnt_o !== 2'b00) begin n_fail++; $display("FAIL rst_gnt: got %b want 00", gnt_o); end
        n_chk++; if ({s_cyc_o, s_stb_o, s_we_o} !== 3'b000) begin n_fail++; $display("FAIL rst_sctl: got %b want 000", {s_cyc_o, s_stb_o, s_we_o}); end
        n_chk++; if ({s_adr_o, s_dat_o, s_be_o} !== 68'h0) begin n_fail++; $display("FAIL rst_sbus: adr %h dat %h be %h want 0", s_adr_o, s_dat_o, s_be_o); end
        n_chk++; if ({m_ack_o, m_err_o} !== 4'b0000) begin n_fail++; $display("FAIL rst_ackerr: got %b want 0000", {m_ack_o, m_err_o}); end
        n_chk++; if (m_dat_o !== 32'hA5A5_0F0F) begin n_fail++; $display("FAIL rdata_bcast: got %h want a5a50f0f", m_dat_o); end
        idle_all();
        rst_in = 1'b1;
        tick();
    endtask

    task automatic test_both_request();
        do_reset();
        drive(0, 1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
        drive(1, 1'b1, 1'b1, 1'b0, 32'h20, 32'h0, 4'hF);
        #1;
        n_chk++; if (s_cyc_o !== 1'b0) begin n_fail++; $display("FAIL arb_latency: s_cyc_o=%b want 0", s_cyc_o); end
        tick();
        n_chk++; if (gnt_o !== 2'b01) begin n_fail++; $display("FAIL first_gnt: got %b want 01", gnt_o); end
        s_ack_i = 1'b1; #1;
        n_chk++; if (m_ack_o !== 2'b01) begin n_fail++; $display("FAIL first_ack: got %b want 01", m_ack_o); end
        tick();
        s_ack_i = 1'b0; drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0); #1;
        n_chk++; if (s_cyc_o !== 1'b0) begin n_fail++; $display("FAIL cyc_drop: s_cyc_o=%b want 0", s_cyc_o); end
        tick();
        n_chk++; if (gnt_o !== 2'b00) begin n_fail++; $display("FAIL idle_gap: got %b want 00", gnt_o); end
        tick();
        n_chk++; if (gnt_o !== 2'b10 || s_adr_o !== 32'h20) begin n_fail++; $display("FAIL second_gnt: gnt %b adr %h want 10/20", gnt_o, s_adr_o); end
        s_ack_i = 1'b1; #1;
        n_chk++; if (m_ack_o !== 2'b10) begin n_fail++; $display("FAIL second_ack: got %b want 10", m_ack_o); end
        tick();
        idle_all();
        tick(); tick();
    endtask

    task automatic test_read_ack();
        do_reset();
        drive(0, 1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
        tick();
        drive(1, 1'b1, 1'b1, 1'b1, 32'h99, 32'h77, 4'h3);
        for (int c = 0; c < 3; c++) begin
            #1;
            n_chk++; if (m_ack_o !== 2'b00 || s_adr_o !== 32'h10 || s_we_o !== 1'b0) begin
                n_fail++; $display("FAIL read_wait%0d: ack %b adr %h we %b want 00/10/0", c, m_ack_o, s_adr_o, s_we_o);
            end
            tick();
        end
        s_ack_i = 1'b1; s_dat_i = 32'hDEAD_BEEF; #1;
        n_chk++; if (m_ack_o !== 2'b01 || m_dat_o !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL read_ack: ack %b dat %h want 01/deadbeef", m_ack_o, m_dat_o);
        end
        tick();
        idle_all(); #1;
        n_chk++; if (m_ack_o !== 2'b00) begin n_fail++; $display("FAIL read_ack_pulse: got %b want 00", m_ack_o); end
        tick(); tick();
    endtask

    task automatic test_timeout(input logic ack_last);
        do_reset();
        drive(1, 1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 4'hF);
        tick();
        for (int c = 0; c < TO; c++) begin
            #1;
            n_chk++; if (m_err_o !== 2'b00 || s_cyc_o !== 1'b1 || gnt_o !== 2'b10) begin
                n_fail++; $display("FAIL to_stall%0d: err %b cyc %b gnt %b want 00/1/10", c, m_err_o, s_cyc_o, gnt_o);
            end
            tick();
        end
        s_ack_i = ack_last; #1;
        if (ack_last) begin
            n_chk++; if (m_ack_o !== 2'b10 || m_err_o !== 2'b00 || s_cyc_o !== 1'b1) begin
                n_fail++; $display("FAIL ack_wins: ack %b err %b cyc %b want 10/00/1", m_ack_o, m_err_o, s_cyc_o);
            end
        end else begin
            n_chk++; if (m_err_o !== 2'b10 || s_cyc_o !== 1'b0 || s_stb_o !== 1'b0) begin
                n_fail++; $display("FAIL to_err: err %b cyc %b stb %b want 10/0/0", m_err_o, s_cyc_o, s_stb_o);
            end
        end
        tick();
        idle_all(); #1;
        n_chk++; if (m_err_o !== 2'b00 || gnt_o !== (ack_last ? 2'b10 : 2'b00)) begin
            n_fail++; $display("FAIL to_after: err %b gnt %b want 00/%b", m_err_o, gnt_o, ack_last ? 2'b10 : 2'b00);
        end
        tick(); tick();
    endtask

    task automatic test_back_to_back();
        do_reset();
        drive(1, 1'b1, 1'b1, 1'b1, 32'hA0, 32'h0, 4'hF);
        tick();
        drive(0, 1'b1, 1'b1, 1'b0, 32'hB0, 32'h0, 4'hF);
        for (int w = 0; w < 3; w++) begin
            drive(1, 1'b1, 1'b1, 1'b1, 32'hA0 + 32'(4*w), 32'hC0DE_0000 + 32'(w), 4'hF);
            s_ack_i = 1'b1; #1;
            n_chk++; if (gnt_o !== 2'b10 || m_ack_o !== 2'b10 || s_dat_o !== 32'hC0DE_0000 + 32'(w) || s_we_o !== 1'b1) begin
                n_fail++; $display("FAIL b2b_wr%0d: gnt %b ack %b dat %h we %b", w, gnt_o, m_ack_o, s_dat_o, s_we_o);
            end
            tick();
            s_ack_i = 1'b0; m_stb_i[1] = 1'b0; #1;
            n_chk++; if (gnt_o !== 2'b10 || s_stb_o !== 1'b0 || s_cyc_o !== 1'b1) begin
                n_fail++; $display("FAIL b2b_gap%0d: gnt %b stb %b cyc %b want 10/0/1", w, gnt_o, s_stb_o, s_cyc_o);
            end
            tick();
        end
        m_cyc_i[1] = 1'b0; #1;
        n_chk++; if (s_cyc_o !== 1'b0) begin n_fail++; $display("FAIL b2b_drop: s_cyc_o=%b want 0", s_cyc_o); end
        tick();
        n_chk++; if (gnt_o !== 2'b00) begin n_fail++; $display("FAIL b2b_idle: got %b want 00", gnt_o); end
        tick();
        n_chk++; if (gnt_o !== 2'b01 || s_adr_o !== 32'hB0) begin n_fail++; $display("FAIL b2b_next: gnt %b adr %h want 01/b0", gnt_o, s_adr_o); end
        idle_all();
        tick(); tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive(1, 1'b1, 1'b1, 1'b0, 32'h60, 32'h0, 4'hF);
        tick();
        tick(); #1;
        rst_in = 1'b0; #1;
        n_chk++; if (s_cyc_o !== 1'b0 || gnt_o !== 2'b00) begin n_fail++; $display("FAIL mid_rst: cyc %b gnt %b want 0/00", s_cyc_o, gnt_o); end
        s_ack_i = 1'b1; #1;
        n_chk++; if ({m_ack_o, m_err_o} !== 4'b0000) begin n_fail++; $display("FAIL mid_rst_ack: got %b want 0000", {m_ack_o, m_err_o}); end
        s_ack_i = 1'b0;
        drive(0, 1'b1, 1'b1, 1'b0, 32'h70, 32'h0, 4'hF);
        rst_in = 1'b1;
        tick();
        n_chk++; if (gnt_o !== 2'b01) begin n_fail++; $display("FAIL mid_rst_regrant: got %b want 01", gnt_o); end
        idle_all();
        tick(); tick();
    endtask

    task automatic test_random();
        int ptr, win, delay;
        logic [NM-1:0] mask, oh;
        logic [31:0] adr [NM];
        logic [31:0] dat [NM];
        logic we [NM];
        logic ack_now, done;
        do_reset();
        ptr = 0;
        for (int it = 0; it < 40; it++) begin
            mask = NM'($urandom_range(1, (1 << NM) - 1));
            win = model_pick(mask, ptr);
            oh = NM'(1) << win;
            delay = $urandom_range(0, TO + 2);
            for (int k = 0; k < NM; k++) begin
                adr[k] = $urandom; dat[k] = $urandom; we[k] = 1'($urandom_range(0, 1));
                if (mask[k]) drive(k, 1'b1, 1'b1, we[k], adr[k], dat[k], 4'($urandom));
            end
            #1;
            n_chk++; if (s_cyc_o !== 1'b0 || gnt_o !== '0) begin n_fail++; $display("FAIL rnd%0d_req: cyc %b gnt %b want 0/0", it, s_cyc_o, gnt_o); end
            tick();
            done = 1'b0;
            for (int c = 0; c <= TO && !done; c++) begin
                ack_now = (c == delay);
                s_ack_i = ack_now; s_dat_i = $urandom; #1;
                n_chk++; if (gnt_o !== oh || s_adr_o !== adr[win] || s_dat_o !== dat[win] || s_we_o !== we[win]) begin
                    n_fail++; $display("FAIL rnd%0d_route c%0d: gnt %b adr %h dat %h want %b %h %h", it, c, gnt_o, s_adr_o, s_dat_o, oh, adr[win], dat[win]);
                end
                n_chk++;
                if (ack_now) begin
                    if (m_ack_o !== oh || m_err_o !== '0 || m_dat_o !== s_dat_i) begin
                        n_fail++; $display("FAIL rnd%0d_ack: ack %b err %b dat %h want %b 0 %h", it, m_ack_o, m_err_o, m_dat_o, oh, s_dat_i);
                    end
                end else if (c == TO) begin
                    if (m_err_o !== oh || m_ack_o !== '0 || s_cyc_o !== 1'b0) begin
                        n_fail++; $display("FAIL rnd%0d_to: err %b ack %b cyc %b want %b 0 0", it, m_err_o, m_ack_o, s_cyc_o, oh);
                    end
                end else begin
                    if (m_ack_o !== '0 || m_err_o !== '0 || s_cyc_o !== 1'b1) begin
                        n_fail++; $display("FAIL rnd%0d_stall c%0d: ack %b err %b cyc %b", it, c, m_ack_o, m_err_o, s_cyc_o);
                    end
                end
                done = ack_now || (c == TO);
                tick();
            end
            idle_all(); #1;
            n_chk++; if (s_cyc_o !== 1'b0 || gnt_o !== ((delay <= TO) ? oh : '0)) begin
                n_fail++; $display("FAIL rnd%0d_rel: cyc %b gnt %b", it, s_cyc_o, gnt_o);
            end
            tick(); #1;
            n_chk++; if (gnt_o !== '0) begin n_fail++; $display("FAIL rnd%0d_idle: gnt %b want 0", it, gnt_o); end
            ptr = (win + 1) % NM;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_all();
        test_reset();
        test_both_request();
        test_read_ack();
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
